// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: carries IF predictions into ID, checks them
// against the beq outcome, drives flush/redirect and keeps statistics.
module branch_resolve_unit #(
    parameter int          PC_W       = 64,
    parameter int          CNT_W      = 32,
    parameter logic [6:0]  BRANCH_OPC = 7'b1100011
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             stall,
    input  logic             if_valid,
    input  logic [PC_W-1:0]  if_pc,
    input  logic             pred_taken,
    input  logic [PC_W-1:0]  pred_target,
    input  logic [31:0]      id_inst,
    input  logic             id_zero_flag,
    input  logic [PC_W-1:0]  id_branch_target,
    input  logic             stats_clear,
    output logic             flush,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    typedef enum logic {
        RUN,
        RECOVER
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic              rec_valid_q, rec_valid_d;
    logic [PC_W-1:0]   rec_pc_q, rec_pc_d;
    logic              rec_pt_q, rec_pt_d;
    logic [PC_W-1:0]   rec_tgt_q, rec_tgt_d;
    logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]  mp_cnt_q, mp_cnt_d;

    logic is_br;
    logic act_taken;
    logic resolve;
    logic mispred;

    always_comb begin
        is_br     = (id_inst[6:0] == BRANCH_OPC);
        act_taken = is_br & id_zero_flag;
        resolve   = rec_valid_q & ~stall & (state_q == RUN);
        mispred   = (act_taken != rec_pt_q)
                  | (act_taken & (rec_tgt_q != id_branch_target))
                  | (~is_br & rec_pt_q);

        flush          = resolve & mispred;
        redirect_valid = flush;
        redirect_pc    = '0;
        if (flush) begin
            redirect_pc = act_taken ? id_branch_target
                                    : rec_pc_q + PC_W'(4);
        end
    end

    // A flushed slot is loaded as a bubble so the wrong-path fetch dies.
    always_comb begin
        rec_valid_d = rec_valid_q;
        rec_pc_d    = rec_pc_q;
        rec_pt_d    = rec_pt_q;
        rec_tgt_d   = rec_tgt_q;
        if (!stall) begin
            rec_valid_d = if_valid & ~flush;
            rec_pc_d    = if_pc;
            rec_pt_d    = pred_taken;
            rec_tgt_d   = pred_target;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (flush)  state_d = RECOVER;
            RECOVER: if (!stall) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (stats_clear) begin
            br_cnt_d = '0;
            mp_cnt_d = '0;
        end else begin
            if (resolve && is_br && br_cnt_q != CNT_MAX)
                br_cnt_d = br_cnt_q + CNT_W'(1);
            if (flush && mp_cnt_q != CNT_MAX)
                mp_cnt_d = mp_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= RUN;
            rec_valid_q <= 1'b0;
            rec_pc_q    <= '0;
            rec_pt_q    <= 1'b0;
            rec_tgt_q   <= '0;
            br_cnt_q    <= '0;
            mp_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            rec_valid_q <= rec_valid_d;
            rec_pc_q    <= rec_pc_d;
            rec_pt_q    <= rec_pt_d;
            rec_tgt_q   <= rec_tgt_d;
            br_cnt_q    <= br_cnt_d;
            mp_cnt_q    <= mp_cnt_d;
        end
    end

    assign branch_count     = br_cnt_q;
    assign mispredict_count = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic
// checked against a rule-level model of the ID record and statistics.
module tb_branch_resolve_unit;

    localparam int CNT_W = 4;
    localparam int CMAX  = 15;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] ADD  = 32'h0000_0033;
    localparam logic [31:0] ADDI = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              stall;
    logic              if_valid;
    logic [63:0]       if_pc;
    logic              pred_taken;
    logic [63:0]       pred_target;
    logic [31:0]       id_inst;
    logic              id_zero_flag;
    logic [63:0]       id_branch_target;
    logic              stats_clear;
    logic              flush;
    logic              redirect_valid;
    logic [63:0]       redirect_pc;
    logic [CNT_W-1:0]  branch_count;
    logic [CNT_W-1:0]  mispredict_count;

    branch_resolve_unit #(.PC_W(64), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .stall            (stall),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .id_inst          (id_inst),
        .id_zero_flag     (id_zero_flag),
        .id_branch_target (id_branch_target),
        .stats_clear      (stats_clear),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: the instruction sitting in ID and whether we are recovering
    bit          m_valid;
    logic [63:0] m_pc;
    bit          m_pt;
    logic [63:0] m_tgt;
    bit          m_rec;
    int          m_bc;
    int          m_mc;

    logic        s_flush;
    logic [63:0] s_rpc;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_pc = '0; m_pt = 0; m_tgt = '0;
        m_rec = 0; m_bc = 0; m_mc = 0;
    endtask

    task automatic cyc(input bit st, input bit ifv, input logic [63:0] pc,
                       input bit pt, input logic [63:0] tgt,
                       input logic [31:0] inst, input bit zf,
                       input logic [63:0] bt, input bit clr);
        bit          isbr, act, res, mis, ef;
        logic [63:0] erpc;
        stall = st; if_valid = ifv; if_pc = pc; pred_taken = pt;
        pred_target = tgt; id_inst = inst; id_zero_flag = zf;
        id_branch_target = bt; stats_clear = clr;
        #2;
        isbr = (inst[6:0] == 7'b1100011);
        act  = isbr && zf;
        res  = m_valid && !st && !m_rec;
        mis  = (act != m_pt) || (act && m_tgt != bt) || (!isbr && m_pt);
        ef   = res && mis;
        erpc = ef ? (act ? bt : m_pc + 64'd4) : 64'd0;
        s_flush = flush;
        s_rpc   = redirect_pc;
        chk("flush", 64'(flush), 64'(ef));
        chk("redirect_valid", 64'(redirect_valid), 64'(ef));
        chk("redirect_pc", redirect_pc, erpc);
        @(posedge clk);
        if (clr) begin
            m_bc = 0; m_mc = 0;
        end else if (res) begin
            if (isbr && m_bc < CMAX) m_bc++;
            if (mis && m_mc < CMAX) m_mc++;
        end
        if (m_rec) begin
            if (!st) m_rec = 0;
        end else if (ef) begin
            m_rec = 1;
        end
        if (!st) begin
            m_valid = ifv && !ef;
            m_pc = pc; m_pt = pt; m_tgt = tgt;
        end
        #1;
        chk("branch_count", 64'(branch_count), 64'(m_bc));
        chk("mispredict_count", 64'(mispredict_count), 64'(m_mc));
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("rst_redirect_pc", redirect_pc, 64'd0);
        chk("rst_branch_count", 64'(branch_count), 64'd0);
        chk("rst_mispredict_count", 64'(mispredict_count), 64'd0);
        arst_n = 1'b1;
    endtask

    initial begin
        int bc0, mc0;
        arst_n = 1'b0; stall = 0; if_valid = 0; if_pc = '0;
        pred_taken = 0; pred_target = '0; id_inst = ADDI;
        id_zero_flag = 0; id_branch_target = '0; stats_clear = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // correct taken prediction
        cyc(0, 1, 64'h40, 1, 64'h80, ADDI, 0, 0, 0);
        cyc(0, 0, 64'h0, 0, 0, BEQ, 1, 64'h80, 0);
        chk("taken_ok_flush", 64'(s_flush), 64'd0);
        chk("taken_ok_bc", 64'(branch_count), 64'd1);

        // mispredicted not-taken; next slot is a killed bubble
        cyc(0, 1, 64'h40, 0, 64'h0, ADDI, 0, 0, 0);
        cyc(0, 1, 64'h44, 1, 64'h44, BEQ, 1, 64'h100, 0);
        chk("mp_nt_flush", 64'(s_flush), 64'd1);
        chk("mp_nt_rpc", s_rpc, 64'h100);
        chk("mp_nt_mc", 64'(mispredict_count), 64'd1);
        cyc(0, 0, 64'h0, 0, 0, BEQ, 1, 64'h200, 0);
        chk("recover_no_flush", 64'(s_flush), 64'd0);

        // wrong target
        cyc(0, 1, 64'h40, 1, 64'h80, ADDI, 0, 0, 0);
        cyc(0, 0, 64'h0, 0, 0, BEQ, 1, 64'h90, 0);
        chk("wrong_tgt_rpc", s_rpc, 64'h90);
        cyc(0, 0, 64'h0, 0, 0, ADDI, 0, 0, 0);

        // predicted taken, actually not taken
        cyc(0, 1, 64'h40, 1, 64'h80, ADDI, 0, 0, 0);
        cyc(0, 0, 64'h0, 0, 0, BEQ, 0, 64'h80, 0);
        chk("pt_nt_rpc", s_rpc, 64'h44);
        cyc(0, 0, 64'h0, 0, 0, ADDI, 0, 0, 0);

        // aliasing on a non-branch at the top of the address space
        bc0 = int'(branch_count); mc0 = int'(mispredict_count);
        cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h80, ADDI, 0, 0, 0);
        cyc(0, 0, 64'h0, 0, 0, ADD, 1, 64'h80, 0);
        chk("alias_flush", 64'(s_flush), 64'd1);
        chk("alias_rpc", s_rpc, 64'h0);
        chk("alias_bc", 64'(branch_count), 64'(bc0));
        chk("alias_mc", 64'(mispredict_count), 64'(mc0 + 1));
        cyc(0, 0, 64'h0, 0, 0, ADDI, 0, 0, 0);

        // mispredicting branch held three cycles by stall
        cyc(0, 1, 64'h200, 0, 64'h0, ADDI, 0, 0, 0);
        mc0 = int'(mispredict_count);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 64'h204, 0, 0, BEQ, 1, 64'h300, 0);
            chk("stall_no_flush", 64'(s_flush), 64'd0);
        end
        cyc(0, 1, 64'h204, 0, 0, BEQ, 1, 64'h300, 0);
        chk("stall_flush", 64'(s_flush), 64'd1);
        chk("stall_rpc", s_rpc, 64'h300);
        chk("stall_mc", 64'(mispredict_count), 64'(mc0 + 1));
        cyc(1, 1, 64'h300, 1, 64'h8, BEQ, 1, 64'h400, 0);
        chk("recover_stall_no_flush", 64'(s_flush), 64'd0);
        cyc(0, 1, 64'h300, 1, 64'h8, BEQ, 1, 64'h400, 0);
        chk("recover_exit_no_flush", 64'(s_flush), 64'd0);
        cyc(0, 0, 64'h0, 0, 0, ADDI, 0, 0, 0);

        // reset pulsed during recovery, then normal resolution resumes
        cyc(0, 1, 64'h500, 0, 0, ADDI, 0, 0, 0);
        cyc(0, 1, 64'h504, 0, 0, BEQ, 1, 64'h600, 0);
        do_reset();
        cyc(0, 1, 64'h600, 0, 0, BEQ, 1, 64'h700, 0);
        chk("post_rst_no_flush", 64'(s_flush), 64'd0);
        cyc(0, 0, 64'h0, 0, 0, BEQ, 1, 64'h700, 0);
        chk("post_rst_flush", 64'(s_flush), 64'd1);
        cyc(0, 0, 64'h0, 0, 0, ADDI, 0, 0, 0);

        // saturation of both counters
        for (int i = 0; i < 18; i++) begin
            cyc(0, 1, 64'h800, 0, 0, ADDI, 0, 0, 0);
            cyc(0, 1, 64'h804, 0, 0, BEQ, 1, 64'h900, 0);
        end
        chk("sat_mc", 64'(mispredict_count), 64'(CMAX));
        chk("sat_bc", 64'(branch_count), 64'(CMAX));

        // clear wins over a same-cycle increment
        cyc(0, 1, 64'h800, 0, 0, ADDI, 0, 0, 0);
        cyc(0, 0, 64'h0, 0, 0, BEQ, 1, 64'h900, 1);
        chk("clr_mc", 64'(mispredict_count), 64'd0);
        chk("clr_bc", 64'(branch_count), 64'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [63:0] pc, tg, bt;
            logic [31:0] inst;
            pc = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 7) == 0) pc = 64'hFFFF_FFFF_FFFF_FFFC;
            tg = 64'(32'h100 * $urandom_range(0, 3));
            bt = 64'(32'h100 * $urandom_range(0, 3));
            inst = ($urandom_range(0, 2) != 0) ? BEQ
                 : (($urandom_range(0, 1) != 0) ? ADD : ADDI);
            cyc(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 4) != 0),
                pc, bit'($urandom_range(0, 1)), tg, inst,
                bit'($urandom_range(0, 1)), bt,
                bit'($urandom_range(0, 40) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Resolves branch predictions in the ID stage. It carries each IF-stage prediction (taken flag and target) alongside the fetched instruction into ID. There it compares the prediction against the actual beq outcome and target, and raises flush/redirect on a mismatch. It is the consumer end of the predictor's IF-side output and the source of pipeline recovery, and it also keeps branch and mispredict statistics counters.

## Interface
- PC_W, 64, program-counter width
- CNT_W, 32, statistics counter width
- BRANCH_OPC, 7'b1100011, opcode of the resolved branch (beq)

- clk  in  1  clock
- arst_n  in  1  reset, asynchronous, active-low
- stall  in  1  pipeline hold of the IF/ID register
- if_valid  in  1  IF holds a real instruction this cycle
- if_pc  in  PC_W  PC of the IF instruction
- pred_taken  in  1  predictor's taken decision for if_pc
- pred_target  in  PC_W  predictor's target for if_pc
- id_inst  in  32  instruction currently in ID
- id_zero_flag  in  1  rs1 == rs2 for the ID instruction
- id_branch_target  in  PC_W  computed branch target for the ID instruction
- stats_clear  in  1  synchronous clear of both counters
- flush  out  1  kill the instruction being fetched / written into IF/ID
- redirect_valid  out  1  fetch must restart at redirect_pc next cycle
- redirect_pc  out  PC_W  corrected fetch PC
- branch_count  out  CNT_W  resolved branches
- mispredict_count  out  CNT_W  mispredictions

## Operation
- **ID record** holds {valid, pc, pred_taken, pred_target}. At each clk edge with stall=0, the record loads {if_valid & ~flush, if_pc, pred_taken, pred_target}. With stall=1 the record holds.
- **Resolution.** Resolution happens only when the record is valid and stall=0.
  - is_br = (id_inst[6:0] == BRANCH_OPC); actual_taken = is_br & id_zero_flag.
  - A misprediction is any of the following:
    - actual_taken != rec.pred_taken;
    - actual_taken and rec.pred_target != id_branch_target;
    - a non-branch with rec.pred_taken=1 (predictor aliasing).
- **Redirect.** On a misprediction, flush=1 and redirect_valid=1. redirect_pc = actual_taken ? id_branch_target : rec.pc + 4, computed modulo 2^PC_W.
- **Quiet cases.** A non-branch with pred_taken=0 never flushes. A stalled cycle, or an invalid record, has flush=0, redirect_valid=0 and redirect_pc=0.
- **FSM.** States are RUN and RECOVER.
  - RUN goes to RECOVER on a misprediction.
  - RECOVER returns to RUN after one unstalled cycle.
  - In RECOVER the record is guaranteed invalid (a bubble was loaded), so no resolution occurs. The FSM holds in RECOVER while stall=1.
- **Counters.**
  - branch_count increments once per resolved is_br record.
  - mispredict_count increments once per misprediction, including aliasing.
  - Both counters saturate at all-ones.
  - stats_clear has priority over a same-cycle increment (result 0).
- **Reset** (arst_n low, asynchronous): record valid=0, pc/pred fields 0, state RUN, counters 0. Therefore flush=0, redirect_valid=0, redirect_pc=0. Reset asserted mid-recovery discards the recovery with no redirect.

## Timing
- flush, redirect_valid and redirect_pc are combinational from the ID record and ID inputs, valid in the same cycle the branch sits in ID with stall=0.
- Redirect takes effect at the next clk edge: the IF/ID record loads a bubble and fetch loads redirect_pc.
- Mispredict penalty is exactly 1 cycle (one bubble).
- Counters update at the edge ending the resolving cycle and are visible 1 cycle later.
- Stall held N cycles on a mispredicting branch: no flush during the N cycles; one flush and one count in the first unstalled cycle.
- A simultaneous flush and if_valid=1 loads valid=0 into the record.

## Test plan
- **Correct taken prediction.** Reset, then IF pc=0x40 with pred_taken=1, pred_target=0x80. Next cycle beq in ID with zero_flag=1 and target 0x80. Required: flush=0, and branch_count reads 1 one cycle later.
- **Mispredicted not-taken.** pc=0x40, pred_taken=0, beq with zero_flag=1 and target 0x100. Required: flush=1, redirect_pc=0x100, next record valid=0, mispredict_count=1.
- **Wrong target and predicted-taken not-taken.**
  - pred_taken=1, pred_target=0x80, actual target 0x90, zero_flag=1: redirect_pc=0x90.
  - pred_taken=1, zero_flag=0, pc=0x40: redirect_pc=0x44.
- **Aliasing.** A non-branch (opcode 0x33) at pc=0xFFFF_FFFF_FFFF_FFFC with pred_taken=1. Required: redirect_pc=0x0 (wrap), branch_count unchanged, mispredict_count +1.
- **Stall and back-to-back.** Mispredicting beq held 3 cycles by stall. Required: flush=0 for 3 cycles, then a single flush and mispredict_count +1 only. A mispredict-shaped input during RECOVER produces no flush.
- **Counters and mid-operation reset.**
  - Preload mispredict_count to all-ones via 2^CNT_W events, or use a small CNT_W=2 build; a further mispredict holds the count at 3.
  - stats_clear with an increment in the same cycle gives 0.
  - arst_n pulsed during RECOVER gives state RUN with all outputs 0.
